// File: rtl/fifo_pkg.sv
// Shared defaults and parameter helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    function automatic int depth_of(input int addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Legal thresholds: almost_full in 1..DEPTH, almost_empty in 0..DEPTH-1.
    function automatic bit thresh_ok(input int addr_w, input int af, input int ae);
        return (af >= 32'sd1) && (af <= depth_of(addr_w)) &&
               (ae >= 32'sd0) && (ae <= depth_of(addr_w) - 32'sd1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, read either async or registered.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit REG_RD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; only changes on an accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else if (re) begin
            rd_data_q <= mem_q[raddr];
        end
    end

    assign rdata = REG_RD ? rd_data_q : mem_q[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through, occupancy count and sticky error flags.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AF_C  = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_C  = PTR_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] ONE_C = PTR_W'(1);

    if (!thresh_ok(ADDR_W, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_fwft: threshold parameters out of range");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
    logic              empty_s, full_s, wr_ok_s, rd_ok_s;
    logic              ovf_q, ovf_d, unf_q, unf_d, valid_q, valid_d;
    logic [DATA_W-1:0] ram_rdata_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign count_s = wr_ptr_q - rd_ptr_q;

    // Accept logic, pointer advance and sticky error flags; a set event beats clr_err.
    always_comb begin
        rd_ok_s  = rd_en & ~empty_s;
        wr_ok_s  = wr_en & (~full_s | rd_ok_s);
        wr_ptr_d = wr_ok_s ? (wr_ptr_q + ONE_C) : wr_ptr_q;
        rd_ptr_d = rd_ok_s ? (rd_ptr_q + ONE_C) : rd_ptr_q;
        valid_d  = rd_ok_s;
        ovf_d    = clr_err ? 1'b0 : ovf_q;
        unf_d    = clr_err ? 1'b0 : unf_q;
        if (wr_en && full_s && !rd_en) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        if (rd_en && empty_s) begin
            unf_d = 1'b1;
        end else begin
            unf_d = unf_d;
        end
    end

    // State registers; reset discards all contents at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            valid_q  <= valid_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_RD (!FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (wr_ok_s),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_ok_s),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

    // In FWFT mode the head word is masked while empty so stale locations never show.
    always_comb begin
        if (FWFT) begin
            data_out = empty_s ? {DATA_W{1'b0}} : ram_rdata_s;
            valid    = ~empty_s;
        end else begin
            data_out = ram_rdata_s;
            valid    = valid_q;
        end
    end

    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_s <= AE_C);
    assign almost_full  = (count_s >= AF_C);
    assign count        = count_s;
    assign wr_ptr       = wr_ptr_q;
    assign rd_ptr       = rd_ptr_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO; next generation of the team's 16-bit, 16-deep FIFO. Adds configurable width, depth and thresholds, a first-word-fall-through (FWFT) mode, an occupancy count and sticky overflow/underflow flags. Sits between the data_mem stimulus source and downstream consumers wherever producer and consumer share one clock. Exports Gray-free binary pointers in the same style as the existing FIFO.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  write request
- rd_en  in  1  read request (FWFT: pop/acknowledge head word)
- data_in  in  DATA_W  write data
- clr_err  in  1  synchronous clear of overflow/underflow
- data_out  out  DATA_W  read data
- valid  out  1  data_out holds a freshly read word (standard) / head word present (FWFT)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_THRESH
- almost_full  out  1  count >= AF_THRESH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- wr_ptr  out  ADDR_W+1  write pointer incl. wrap bit
- rd_ptr  out  ADDR_W+1  read pointer incl. wrap bit
- overflow  out  1  sticky: write attempted while full and not simultaneously read
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted (wr_ok) = wr_en & (!full | rd_ok); stores data_in at mem[wr_ptr[ADDR_W-1:0]], wr_ptr += 1.
- Read accepted (rd_ok) = rd_en & !empty; rd_ptr += 1.
- Pointers wrap modulo 2**(ADDR_W+1); full = (MSBs differ, lower bits equal); empty = pointers equal; count = wr_ptr - rd_ptr, mod 2**(ADDR_W+1).
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither.
- Full + wr_en + rd_en: both accepted, count stays DEPTH, no overflow.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow sets.
- overflow sets on wr_en & full & !rd_en; underflow sets on rd_en & empty. Both hold until clr_err or reset; a set event in the same cycle as clr_err wins.
- Standard (FWFT=0): on rd_ok, data_out <= mem[rd_ptr] at the edge; valid <= rd_ok. data_out holds its value otherwise.
- FWFT=1: data_out = mem[rd_ptr] combinationally; valid = !empty; rd_en consumes the displayed word.
- Memory contents are not reset; reads never return unwritten locations.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_THRESH=0, disallowed), data_out=0, valid=0, overflow=0, underflow=0.
- Reset is asynchronous on assert, released synchronously by the system; reset mid-transfer discards all contents immediately.
- All flags and count are registered or derived solely from registered pointers: update the edge after the causing request.
- Standard mode read latency: 1 cycle (rd_en at edge N -> data_out/valid at edge N).
- FWFT latency: word written at edge N is visible on data_out with valid=1 after edge N.
- Write-to-read turnaround: a word written at edge N may be read at edge N+1.

## Structure
- Shared package/include fifo_pkg: default DATA_W/ADDR_W, DEPTH derivation, pointer-width localparam, threshold range checks.
- One sub-module: fifo_ram — DEPTH x DATA_W dual-port register array, synchronous write, read port async (FWFT) or registered (standard) selected by parameter.
- Pointer/flag/count logic and error flags stay in the top.

## Test plan
- Reset then 16 writes 0x0001..0x0010, no reads -> full=1, count=16, almost_full from 12th write, wr_ptr=0x10, rd_ptr=0.
- 17th write while full -> overflow=1, count stays 16, contents unchanged; clr_err -> overflow=0.
- Read 16 words (FWFT=0) -> data_out 0x0001..0x0010 one cycle after each rd_en, valid pulses, empty=1 after last; extra rd_en -> underflow=1.
- Full FIFO with wr_en+rd_en together for 20 cycles -> count stays 16, no overflow, output order preserved across pointer wrap (wr_ptr wraps 0x1F->0x00).
- FWFT=1: single write 0xBEEF -> next cycle data_out=0xBEEF, valid=1 without rd_en; rd_en -> valid=0, empty=1.
- Assert reset with count=9 mid-stream -> immediately count=0, empty=1, valid=0, data_out=0, pointers 0.
